sync_fifo: RTL and testbench

- Synchronous single-clock first-word-fall-through (FWFT) FIFO.
- Used as the input buffer of the alignment stage. That stage uses the flags directly in its handshake:
  - avail = ~almost_full & ~full
  - data_read is consumed combinationally whenever empty is low.
- Storage is a register array of NUM_SLOTS words, indexed by read and write pointers, with an occupancy counter.

---
 rtl/sync_fifo.sv | 64 ++++++
 tb/tb_sync_fifo.sv | 118 +++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with occupancy-decoded flags.
// Define SYNC_FIFO_CHECK_EN to report overflow/underflow attempts with a cycle stamp.
module sync_fifo #(
  parameter int NUM_SLOTS     = 4,
  parameter int LOG_NUM_SLOTS = 2,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_write,
  input  logic                  write,
  output logic                  full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] data_read,
  input  logic                  next_read,
  output logic                  empty
);
  localparam logic [LOG_NUM_SLOTS-1:0] PTR_ONE  = 1;
  localparam logic [LOG_NUM_SLOTS:0]   CNT_ONE  = 1;
  localparam logic [LOG_NUM_SLOTS:0]   CNT_FULL = (LOG_NUM_SLOTS+1)'(NUM_SLOTS);
  localparam logic [LOG_NUM_SLOTS:0]   CNT_AF   = (LOG_NUM_SLOTS+1)'(NUM_SLOTS - 1);
  logic [DATA_WIDTH-1:0]    mem_q [NUM_SLOTS];
  logic [LOG_NUM_SLOTS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LOG_NUM_SLOTS:0]   count_q, count_d;
  logic                     do_write, do_read;
  assign full        = count_q == CNT_FULL;
  assign almost_full = count_q == CNT_AF;
  assign empty       = count_q == '0;
  assign data_read   = empty ? '0 : mem_q[rd_ptr_q];
  assign do_write    = write & ~full;
  assign do_read     = next_read & ~empty;
  always_comb begin
    wr_ptr_d = do_write ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_read ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = (do_write && !do_read) ? count_q + CNT_ONE :
               (do_read && !do_write) ? count_q - CNT_ONE : count_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // Storage is deliberately not reset; data_read masks stale words while empty.
  always_ff @(posedge clk) begin
    if (rst && do_write) mem_q[wr_ptr_q] <= data_write;
  end
`ifdef SYNC_FIFO_CHECK_EN
  logic [15:0] cyc_q;
  always_ff @(posedge clk) begin
    if (!rst) cyc_q <= '0;
    else begin
      cyc_q <= cyc_q + 16'd1;
      if (write && full) $display("FIFO: cycle %d, overflow", cyc_q);
      if (next_read && empty) $display("FIFO: cycle %d, underflow", cyc_q);
    end
  end
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed stimulus against a queue-based reference of the FWFT FIFO,
// checked every cycle plus literal expectations along the way.
module tb_sync_fifo;
  localparam int N = 4;
  localparam int W = 64;
  logic         clk = 0;
  logic         rst = 0;
  logic [W-1:0] data_write = '0;
  logic         write = 0;
  logic         next_read = 0;
  logic         full, almost_full, empty;
  logic [W-1:0] data_read;
  int           checks = 0;
  int           errors = 0;
  bit           en = 0;
  logic [W-1:0] q[$];
  sync_fifo #(.NUM_SLOTS(N), .LOG_NUM_SLOTS(2), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .data_write(data_write), .write(write),
    .full(full), .almost_full(almost_full), .data_read(data_read),
    .next_read(next_read), .empty(empty)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (!rst) q.delete();
    else begin
      bit dw, dr;
      dw = write && q.size() < N;
      dr = next_read && q.size() > 0;
      if (dr) void'(q.pop_front());
      if (dw) q.push_back(data_write);
    end
  end
  always @(negedge clk) begin
    if (en) begin
      chk("model_empty", {63'd0, empty}, {63'd0, q.size() == 0});
      chk("model_full", {63'd0, full}, {63'd0, q.size() == N});
      chk("model_af", {63'd0, almost_full}, {63'd0, q.size() == N - 1});
      chk("model_data", data_read, q.size() == 0 ? '0 : q[0]);
    end
  end
  task automatic cyc(input logic w, input logic [W-1:0] d, input logic r, input logic rs = 1);
    write = w; data_write = d; next_read = r; rst = rs;
    @(posedge clk);
    #1;
    write = 0; next_read = 0; rst = 1;
  endtask
  logic [W-1:0] a[5];
  initial begin
    for (int i = 0; i < 5; i++) a[i] = 64'hA000_0000_0000_0001 + 64'(i) * 64'h1111;
    cyc(0, '0, 0, 0);
    cyc(0, '0, 0, 0);
    en = 1;
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_full", {63'd0, full}, 64'd0);
    chk("rst_af", {63'd0, almost_full}, 64'd0);
    chk("rst_data", data_read, 64'd0);
    cyc(1, a[0], 0);
    chk("fill1_empty", {63'd0, empty}, 64'd0);
    chk("fill1_data", data_read, 64'hA000_0000_0000_0001);
    cyc(1, a[1], 0);
    cyc(1, a[2], 0);
    chk("fill3_af", {63'd0, almost_full}, 64'd1);
    cyc(1, a[3], 0);
    chk("fill4_full", {63'd0, full}, 64'd1);
    chk("fill4_af", {63'd0, almost_full}, 64'd0);
    cyc(1, a[4], 0);
    chk("overflow_full", {63'd0, full}, 64'd1);
    chk("overflow_head", data_read, 64'hA000_0000_0000_0001);
    for (int i = 0; i < 4; i++) begin
      chk("drain_head", data_read, 64'hA000_0000_0000_0001 + 64'(i) * 64'h1111);
      cyc(0, '0, 1);
    end
    chk("drain_empty", {63'd0, empty}, 64'd1);
    chk("drain_data0", data_read, 64'd0);
    cyc(0, '0, 1);
    chk("underflow_empty", {63'd0, empty}, 64'd1);
    cyc(1, 64'hD000_0000_0000_0000, 0);
    cyc(1, 64'hD000_0000_0000_0001, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 64'hD000_0000_0000_0000 + 64'(i + 2), 1);
      chk("conc_head", data_read, 64'hD000_0000_0000_0000 + 64'(i + 1));
      chk("conc_full", {63'd0, full}, 64'd0);
      chk("conc_af", {63'd0, almost_full}, 64'd0);
    end
    cyc(1, 64'hE0, 0);
    cyc(1, 64'hE1, 0);
    chk("pre_sim_full", {63'd0, full}, 64'd1);
    cyc(1, 64'hBBBB, 1);
    chk("sim_full_af", {63'd0, almost_full}, 64'd1);
    chk("sim_full_head", data_read, 64'hD000_0000_0000_000B);
    cyc(0, '0, 1);
    chk("sim_drain1", data_read, 64'hE0);
    cyc(0, '0, 1);
    chk("sim_drain2", data_read, 64'hE1);
    cyc(0, '0, 1);
    chk("sim_drain_empty", {63'd0, empty}, 64'd1);
    for (int i = 0; i < 3; i++) cyc(1, 64'hF0 + 64'(i), 0);
    chk("pre_rst_af", {63'd0, almost_full}, 64'd1);
    cyc(1, 64'hFF, 0, 0);
    chk("midrst_empty", {63'd0, empty}, 64'd1);
    chk("midrst_data", data_read, 64'd0);
    cyc(1, 64'hC0C0, 0);
    chk("post_rst_data", data_read, 64'hC0C0);
    cyc(0, '0, 1);
    chk("final_empty", {63'd0, empty}, 64'd1);
    @(negedge clk);
    en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
